// File: rtl/pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs
// Parametrised pipeline stage register with a valid/ready handshake. It is used
// at every core stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
//
// Parameters
//   DATA_W  payload width. The default packing, MSB first, is
//           op1(32) op2(32) reg_we(1) reg_waddr(5) inst(32) inst_addr(32).
//   BUBBLE  value shown on out_data_o whenever the stage is empty.
//           The default is a NOP (0x00000013) in the inst field.
//   SKID    1: two-entry skid buffer, and in_ready_o is decoded from the
//           state register only.
//           0: single entry, and in_ready_o passes downstream back-pressure
//           through.
//   CNT_W   width of the saturating stall counter.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active high
//   flush_i      synchronous flush; empties the stage (highest priority)
//   in_valid_i   upstream payload valid
//   in_ready_o   stage can accept this cycle
//   in_data_i    upstream payload
//   out_valid_o  out_data_o holds a real entry
//   out_ready_i  downstream accepts
//   out_data_o   head payload, or BUBBLE when empty
//   count_o      entries held (0..2 with SKID=1, 0..1 with SKID=0)
//   stall_cnt_o  saturating count of cycles with out_valid_o & !out_ready_i
// ---------------------------------------------------------------------------
module pipe_stage_hs #(
    parameter int unsigned         DATA_W = 134,
    parameter logic [DATA_W-1:0]   BUBBLE = DATA_W'(134'h13_0000_0000),
    parameter bit                  SKID   = 1'b1,
    parameter int unsigned         CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  skid_q;
    logic [CNT_W-1:0]   stall_q;
    logic               accept;
    logic               take;

    // Handshake decode: the head entry is always in main_q.
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign accept      = in_valid_i & in_ready_o;
    assign take        = out_valid_o & out_ready_i;

    // Upstream ready: registered-only with skid, pass-through without.
    if (SKID) begin : g_skid_ready
        assign in_ready_o = (state_q != ST_FULL);
    end else begin : g_pass_ready
        assign in_ready_o = ~out_valid_o | out_ready_i;
    end

    // Occupancy decode.
    always_comb begin
        count_o = 2'd0;
        case (state_q)
            ST_ONE:  count_o = 2'd1;
            ST_FULL: count_o = 2'd2;
            default: count_o = 2'd0;
        endcase
    end

    // Stage FSM and payload registers. Flush overrides any accept or take in
    // the same cycle; those transfers complete from the neighbours' view and
    // are discarded here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q <= ST_ONE;
                        main_q  <= in_data_i;
                    end
                end
                ST_ONE: begin
                    if (accept && take) begin
                        main_q <= in_data_i;
                    end else if (accept) begin
                        // Reachable only with SKID=1. With SKID=0,
                        // in_ready_o is low here unless a take also occurs.
                        state_q <= ST_FULL;
                        skid_q  <= in_data_i;
                    end else if (take) begin
                        state_q <= ST_EMPTY;
                        main_q  <= BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        state_q <= ST_ONE;
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    main_q  <= BUBBLE;
                    skid_q  <= BUBBLE;
                end
            endcase
        end
    end

    // Saturating stall counter. It sees the pre-flush view and only reset
    // clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_hs
// Scoreboard bench for pipe_stage_hs. It drives two instances side by side:
//   dut0: SKID=1, CNT_W=16
//   dut1: SKID=0, CNT_W=4
// Each instance has its own upstream source, which holds a payload until it
// is accepted. The reference model treats the stage as a FIFO with an
// occupancy limit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stage_hs;

    localparam int unsigned W   = 134;
    localparam int unsigned CW0 = 16;
    localparam int unsigned CW1 = 4;
    // NOP in the inst field (bits 63:32); every other field is zero.
    localparam logic [W-1:0] BUB = {32'h0, 32'h0, 1'b0, 5'h0, 32'h0000_0013, 32'h0};

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            out_ready;
    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    logic [1:0]      out_valid;
    logic [W-1:0]    in_data  [2];
    logic [W-1:0]    out_data [2];
    logic [1:0]      count    [2];
    logic [CW0-1:0]  stall0;
    logic [CW1-1:0]  stall1;

    int checks   = 0;
    int failures = 0;

    // Upstream sources and the expected output order.
    logic [W-1:0] s0[$];
    logic [W-1:0] s1[$];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    // Reference state: occupancy now and after the next edge, the
    // expected ready, and the expected stall count.
    int         occ_cur   [2] = '{0, 0};
    int         occ_nxt   [2] = '{0, 0};
    logic [1:0] rdy_exp       = 2'b11;
    int         stall_exp [2] = '{0, 0};
    int         stall_max [2] = '{65535, 15};

    always #5 clk = ~clk;

    pipe_stage_hs #(.SKID(1'b1), .CNT_W(CW0)) u_dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid[0]),
        .in_ready_o  (in_ready[0]),
        .in_data_i   (in_data[0]),
        .out_valid_o (out_valid[0]),
        .out_ready_i (out_ready),
        .out_data_o  (out_data[0]),
        .count_o     (count[0]),
        .stall_cnt_o (stall0)
    );

    pipe_stage_hs #(.SKID(1'b0), .CNT_W(CW1)) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid[1]),
        .in_ready_o  (in_ready[1]),
        .in_data_i   (in_data[1]),
        .out_valid_o (out_valid[1]),
        .out_ready_i (out_ready),
        .out_data_o  (out_data[1]),
        .count_o     (count[1]),
        .stall_cnt_o (stall1)
    );

    task automatic chk(input string name, input int k, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, k, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_payload();
        return W'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // Reset values must appear without waiting for a clock edge.
    task automatic rst_checks();
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, W'(out_valid[k]), W'(1'b0));
            chk("rst_out_data",  k, out_data[k], BUB);
            chk("rst_count",     k, W'(count[k]), W'(2'd0));
            chk("rst_in_ready",  k, W'(in_ready[k]), W'(1'b1));
            chk("rst_stall",     k, W'((k == 0) ? int'(stall0) : int'(stall1)), W'(0));
        end
    endtask

    task automatic clear_model();
        s0.delete(); s1.delete(); q0.delete(); q1.delete();
        occ_cur   = '{0, 0};
        occ_nxt   = '{0, 0};
        stall_exp = '{0, 0};
        rdy_exp   = 2'b11;
    endtask

    // Pulse reset between clock edges, with the stage possibly holding data.
    task automatic mid_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        rst_checks();
        clear_model();
        in_valid  = 2'b00;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Drive one cycle of stimulus for the coming edge and advance the model.
    task automatic step(input logic ordy, input logic fl);
        int           sz;
        logic         v;
        logic         acc;
        logic         tk;
        logic [W-1:0] d;
        @(posedge clk); #1;
        out_ready = ordy;
        flush     = fl;
        for (int k = 0; k < 2; k++) begin
            occ_cur[k] = occ_nxt[k];
            sz = (k == 0) ? s0.size() : s1.size();
            v  = (sz > 0);
            d  = '0;
            if (v) d = (k == 0) ? s0[0] : s1[0];
            in_valid[k] = v;
            in_data[k]  = d;
            rdy_exp[k]  = (k == 0) ? (occ_cur[k] < 2) : ((occ_cur[k] == 0) || ordy);
            acc = v && rdy_exp[k];
            tk  = (occ_cur[k] > 0) && ordy;
            if (acc) begin
                if (k == 0) void'(s0.pop_front()); else void'(s1.pop_front());
            end
            if (fl) begin
                occ_nxt[k] = 0;
            end else begin
                occ_nxt[k] = occ_cur[k] - (tk ? 1 : 0) + (acc ? 1 : 0);
                if (acc) begin
                    if (k == 0) q0.push_back(d); else q1.push_back(d);
                end
            end
        end
    endtask

    // Monitor: check the visible state and, on a take, pop and compare.
    logic [W-1:0] mon_exp;
    int           mon_qs;
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk("out_valid", k, W'(out_valid[k]), W'(occ_cur[k] > 0));
                chk("in_ready",  k, W'(in_ready[k]), W'(rdy_exp[k]));
                chk("count",     k, W'(count[k]), W'(occ_cur[k]));
                chk("stall_cnt", k, W'((k == 0) ? int'(stall0) : int'(stall1)), W'(stall_exp[k]));
                if (out_valid[k]) begin
                    mon_qs = (k == 0) ? q0.size() : q1.size();
                    if (mon_qs == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out dut%0d t=%0t actual=%h required=none",
                                 k, $time, out_data[k]);
                    end else begin
                        mon_exp = (k == 0) ? q0[0] : q1[0];
                        chk("out_data", k, out_data[k], mon_exp);
                        if (out_ready) begin
                            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        end
                    end
                end else begin
                    chk("out_bubble", k, out_data[k], BUB);
                end
                if (flush) begin
                    if (k == 0) q0.delete(); else q1.delete();
                end
                if ((occ_cur[k] > 0) && !out_ready && (stall_exp[k] < stall_max[k]))
                    stall_exp[k]++;
            end
        end
    end

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b0;
        in_valid    = 2'b00;
        in_data[0]  = '0;
        in_data[1]  = '0;
        #2;
        rst_checks();
        @(posedge clk); #2;
        rst = 1'b0;

        // Streaming at full throughput.
        for (int i = 1; i <= 4; i++) begin
            s0.push_back(W'(i));
            s1.push_back(W'(i));
        end
        repeat (7) step(1'b1, 1'b0);

        // Back-pressure: A and B fill the skid stage, and C waits upstream.
        s0.push_back(W'(32'hA)); s0.push_back(W'(32'hB)); s0.push_back(W'(32'hC));
        s1.push_back(W'(32'hA)); s1.push_back(W'(32'hB)); s1.push_back(W'(32'hC));
        repeat (4) step(1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0);

        // Flush while full, with a take in the same cycle.
        s0.push_back(W'(32'h51)); s0.push_back(W'(32'h52));
        s1.push_back(W'(32'h51)); s1.push_back(W'(32'h52));
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);

        // A long stall saturates the 4-bit counter.
        s0.push_back(W'(32'h77));
        s1.push_back(W'(32'h77));
        repeat (22) step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);

        // Reset while entries are held.
        s0.push_back(W'(32'h91)); s0.push_back(W'(32'h92));
        s1.push_back(W'(32'h91)); s1.push_back(W'(32'h92));
        repeat (2) step(1'b0, 1'b0);
        mid_reset();
        repeat (2) step(1'b1, 1'b0);

        // Randomised traffic with occasional flushes and one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) mid_reset();
            if (($urandom_range(0, 3) != 0) && (s0.size() < 4)) s0.push_back(rnd_payload());
            if (($urandom_range(0, 3) != 0) && (s1.size() < 4)) s1.push_back(rnd_payload());
            step(($urandom_range(0, 3) != 0) || (c % 200 > 180 ? 1'b0 : 1'b0),
                 ($urandom_range(0, 40) == 0));
        end

        // Drain whatever is still held.
        s0.delete();
        s1.delete();
        repeat (5) step(1'b1, 1'b0);
        @(negedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register with valid/ready handshake. Generic successor to the fixed ID/EXE latch, for use at every core stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB). Features:
- Packed payload of configurable width.
- Synchronous flush that inserts a configurable bubble.
- Optional two-entry skid buffer, so the upstream ready has no combinational path from the downstream ready.
- Saturating back-pressure cycle counter for performance debug.

## Interface
Parameters:
- DATA_W, 134: payload width. Default packing is op1 32 + op2 32 + reg_we 1 + reg_waddr 5 + inst 32 + inst_addr 32.
- BUBBLE, 134'h0000_0013 in the inst field, all other fields zero: value driven on out_data_o when the stage is empty.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush; empties the stage.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept this cycle.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  out_data_o holds a real entry.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  head payload, or BUBBLE when empty.
- count_o  out  2  entries held: 0..2 with SKID=1, 0..1 with SKID=0.
- stall_cnt_o  out  CNT_W  saturating count of cycles with out_valid_o & !out_ready_i.

## Operation
- Accept: in_valid_i & in_ready_o at a rising edge. Take: out_valid_o & out_ready_i at a rising edge.
- State machine (SKID=1) with states EMPTY, ONE, FULL:
  - EMPTY: accept -> ONE, main <= in_data_i.
  - ONE, accept & take: stay ONE, main <= in_data_i.
  - ONE, accept only: -> FULL, skid <= in_data_i.
  - ONE, take only: -> EMPTY, main <= BUBBLE.
  - ONE, neither: hold.
  - FULL: in_ready_o = 0. Take -> ONE, main <= skid. Otherwise hold.
- in_ready_o (SKID=1) = (state != FULL), decoded from the state register only.
- SKID=0: states EMPTY/ONE only; in_ready_o = !out_valid_o | out_ready_i (pass-through back-pressure). Accept with take replaces main in the same edge.
- out_valid_o = (state != EMPTY). out_data_o = main register, which is loaded with BUBBLE whenever the stage empties.
- Payload ordering is strictly FIFO. A payload is never duplicated or dropped except by flush.
- Flush (highest priority):
  - Next state is EMPTY; main and skid <= BUBBLE; count_o -> 0.
  - An accept or take in the flush cycle is consumed and discarded. Upstream and downstream treat it as transferred.
- stall_cnt_o:
  - Increments each edge where out_valid_o & !out_ready_i, evaluated before any flush.
  - Saturates at all-ones.
  - Cleared only by rst_i.

## Timing
- Reset (async, immediate): state EMPTY; out_valid_o 0; out_data_o BUBBLE; in_ready_o 1; count_o 0; stall_cnt_o 0. Skid register is BUBBLE.
- Deassertion of rst_i is assumed synchronised externally. The first accept can occur at the first edge after deassertion.
- Latency: an accepted payload appears on out_data_o with out_valid_o one cycle after the accept edge (one register stage). A payload written to the skid reaches out_data_o on the edge of the next take.
- Throughput: one transfer per cycle when out_ready_i is held high, for both SKID values.
- SKID=1: in_ready_o deasserts the cycle after the stage becomes FULL and reasserts the cycle after the first take from FULL. No same-cycle combinational path from out_ready_i to in_ready_o.
- Reset asserted mid-transfer: all held entries are lost. Outputs take their reset values asynchronously, without waiting for a clock edge.
- Flush concurrent with FULL and take: the result is EMPTY. The skid entry is not promoted.

## Test plan
- Reset with rst_i pulsed between edges → outputs immediately show out_valid_o=0, out_data_o=BUBBLE (inst field 0x00000013), count_o=0, in_ready_o=1.
- Streaming with out_ready_i=1, payloads 1,2,3,4 on consecutive cycles → out_data_o shows 1,2,3,4 one cycle later each; in_ready_o stays 1; stall_cnt_o=0.
- Back-pressure (SKID=1): hold out_ready_i=0 and offer A,B,C → A and B accepted, count_o=2, in_ready_o=0, C is held upstream. Release out_ready_i → outputs A,B,C in order; stall_cnt_o equals the number of cycles held.
- Flush while FULL with out_ready_i=1 → next cycle out_valid_o=0, out_data_o=BUBBLE, count_o=0. Neither entry appears later.
- SKID=0 under back-pressure: out_valid_o=1 and out_ready_i=0 give in_ready_o=0 in the same cycle. Setting out_ready_i=1 gives in_ready_o=1 combinationally, and the new payload replaces the old one at the edge.
- CNT_W=4 with a 20-cycle stall → stall_cnt_o saturates at 15 and holds.
